demux1to8_deframer: RTL and testbench

//  Receive end of the 8:1 mux lane. Takes the serialised stream one slot per accepted beat (slot i carries data[i]).

---
 rtl/demux_deframer_pkg.sv | 13 +
 rtl/demux_slot_ctr.sv | 32 +++
 rtl/demux1to8_deframer.sv | 123 ++++++++++++
 tb/tb_demux1to8_deframer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_deframer_pkg.sv
// Shared types and defaults for the 1:8 demux deframer.
package demux_deframer_pkg;

    typedef enum logic [0:0] {FILL, STALL} state_e;

    localparam int unsigned LANES_DEF = 8;
    localparam int unsigned WIDTH_DEF = 1;

    function automatic int unsigned slot_wrap(input int unsigned cur, input int unsigned lanes);
        return (cur == lanes - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// Slot counter for the deframer: increments per accepted beat, loads 1 on sync.
module demux_slot_ctr
    import demux_deframer_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             sync,
    output logic [SEL_W-1:0] slot,
    output logic             last
);

    logic [SEL_W-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (sync) begin
            // Sync beat itself fills lane 0, so the next beat goes to lane 1.
            slot_q <= SEL_W'(1);
        end else if (inc) begin
            slot_q <= SEL_W'(slot_wrap(32'(slot_q), LANES));
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == SEL_W'(LANES - 1));

endmodule

// File: rtl/demux1to8_deframer.sv
// Rebuilds parallel frames from a slot-serial stream with valid/ready on both sides.
// Optional frame_err output enabled by defining DEMUX_FRAME_ERR_EN.
module demux1to8_deframer
    import demux_deframer_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SEL_W = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sync,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]       slot
`ifdef DEMUX_FRAME_ERR_EN
    ,
    output logic                   frame_err
`endif
);

    state_e                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [LANES*WIDTH-1:0] out_data_q;
    logic [LANES*WIDTH-1:0] shadow_q;
    logic [LANES*WIDTH-1:0] frame_next;
    logic                   accept;
    logic                   complete;
    logic                   last;
    int unsigned            wr_base;

    assign accept   = in_valid && in_ready_q;
    assign complete = accept && !in_sync && last;

    demux_slot_ctr #(
        .LANES (LANES),
        .SEL_W (SEL_W)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .sync  (accept && in_sync),
        .slot  (slot),
        .last  (last)
    );

    // Shadow with the current beat merged in; lets the last beat bypass into the output.
    always_comb begin
        frame_next = shadow_q;
        wr_base    = in_sync ? 0 : 32'(slot) * WIDTH;
        frame_next[wr_base +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            shadow_q    <= '0;
        end else begin
            if (accept) begin
                shadow_q <= frame_next;
            end
            unique case (state_q)
                FILL: begin
                    if (complete) begin
                        if (!out_valid_q || out_ready) begin
                            out_data_q  <= frame_next;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= STALL;
                            in_ready_q <= 1'b0;
                        end
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                STALL: begin
                    if (out_ready) begin
                        out_data_q <= shadow_q;
                        state_q    <= FILL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef DEMUX_FRAME_ERR_EN
    logic sync_seen_q;
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_seen_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (accept && in_sync) begin
                sync_seen_q <= 1'b1;
            end
            // Truncated frame, or a new frame started without sync after alignment was found.
            frame_err_q <= accept && ((in_sync && slot != '0) ||
                                      (!in_sync && slot == '0 && sync_seen_q));
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_demux1to8_deframer.sv
// Directed, table-driven bench for demux1to8_deframer.
module tb_demux1to8_deframer;

    localparam int unsigned LANES = 8;
    localparam int unsigned WIDTH = 1;
    localparam int unsigned SEL_W = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_sync;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [SEL_W-1:0]       slot;
`ifdef DEMUX_FRAME_ERR_EN
    logic                   frame_err;
`endif

    int checks = 0;
    int errors = 0;

    demux1to8_deframer #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .slot      (slot)
`ifdef DEMUX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] word;
        logic       sync;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat and return #1 after the accepting edge.
    task automatic send_beat(input logic d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic s);
        for (int i = 0; i < 8; i++) begin
            send_beat(w[i], (i == 0) ? s : 1'b0);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{word: 8'hAA, sync: 1'b1, exp: 8'hAA};
        vecs[1] = '{word: 8'h3C, sync: 1'b1, exp: 8'h3C};
        vecs[2] = '{word: 8'hC3, sync: 1'b1, exp: 8'hC3};
        vecs[3] = '{word: 8'h00, sync: 1'b1, exp: 8'h00};
        vecs[4] = '{word: 8'hFF, sync: 1'b0, exp: 8'hFF};
        vecs[5] = '{word: 8'h01, sync: 1'b0, exp: 8'h01};
        vecs[6] = '{word: 8'h80, sync: 1'b1, exp: 8'h80};
        vecs[7] = '{word: 8'h5A, sync: 1'b0, exp: 8'h5A};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sync   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
`ifdef DEMUX_FRAME_ERR_EN
        check("rst_frame_err", 32'(frame_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        // Back-to-back frames with out_ready=1; in_ready must never drop.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 8; i++) begin
                check("tbl_in_ready", 32'(in_ready), 32'd1);
                send_beat(vecs[v].word[i], (i == 0) ? vecs[v].sync : 1'b0);
                if (i == 6) check("tbl_pre_valid", 32'(out_valid), 32'd0);
            end
            check("tbl_out_valid", 32'(out_valid), 32'd1);
            check("tbl_out_data", 32'(out_data), 32'(vecs[v].exp));
            check("tbl_slot", 32'(slot), 32'd0);
        end
        idle_cycle();
        check("pop_out_valid", 32'(out_valid), 32'd0);

        // Output held across two frames -> stall, then drain.
        out_ready = 1'b0;
        send_word(8'h96, 1'b1);
        check("st_f1_valid", 32'(out_valid), 32'd1);
        check("st_f1_data", 32'(out_data), 32'h96);
        send_beat(1'b1, 1'b1);
        check("st_hold_data", 32'(out_data), 32'h96);
        for (int i = 1; i < 8; i++) send_beat(1'b0, 1'b0);
        check("st_in_ready", 32'(in_ready), 32'd0);
        check("st_out_data", 32'(out_data), 32'h96);
        check("st_out_valid", 32'(out_valid), 32'd1);
        idle_cycle();
        check("st_still_data", 32'(out_data), 32'h96);
        check("st_still_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        idle_cycle();
        check("st_f2_data", 32'(out_data), 32'h01);
        check("st_f2_valid", 32'(out_valid), 32'd1);
        check("st_f2_ready", 32'(in_ready), 32'd1);
        idle_cycle();
        check("st_drain_valid", 32'(out_valid), 32'd0);

        // Truncated frame: 3 beats, then sync realigns.
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0);
        check("sy_slot3", 32'(slot), 32'd3);
        send_beat(1'b1, 1'b1);
        check("sy_slot1", 32'(slot), 32'd1);
`ifdef DEMUX_FRAME_ERR_EN
        check("sy_frame_err", 32'(frame_err), 32'd1);
`endif
        send_beat(1'b1, 1'b0);
`ifdef DEMUX_FRAME_ERR_EN
        check("sy_frame_err_clr", 32'(frame_err), 32'd0);
`endif
        for (int i = 2; i < 8; i++) send_beat(1'b1, 1'b0);
        check("sy_out_valid", 32'(out_valid), 32'd1);
        check("sy_out_data", 32'(out_data), 32'hFF);
        check("sy_slot0", 32'(slot), 32'd0);

        // Sync arriving at the last slot must not complete the partial frame.
        for (int i = 0; i < 7; i++) send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b1);
        check("sl_no_complete", 32'(out_valid), 32'd0);
        check("sl_slot1", 32'(slot), 32'd1);
        for (int i = 1; i < 8; i++) send_beat(1'b0, 1'b0);
        check("sl_out_valid", 32'(out_valid), 32'd1);
        check("sl_out_data", 32'(out_data), 32'h00);
        idle_cycle();

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b1);
        check("rs_stall_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        check("rs_slot", 32'(slot), 32'd0);
        check("rs_out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle_cycle();
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("rs_no_spurious", 32'(out_valid), 32'd0);
        end

        // Random gaps must not advance slot.
        begin
            logic [7:0] w;
            int sent;
            int budget;
            w = 8'h5A;
            sent = 0;
            budget = 200;
            while (sent < 8 && budget > 0) begin
                budget--;
                if ($urandom_range(1) == 0) begin
                    idle_cycle();
                    check("gap_slot", 32'(slot), 32'(sent));
                end else begin
                    send_beat(w[sent], (sent == 0) ? 1'b1 : 1'b0);
                    sent++;
                    if (sent < 8) check("gap_beat_slot", 32'(slot), 32'(sent));
                end
            end
            check("gap_budget", 32'(sent), 32'd8);
            check("gap_out_valid", 32'(out_valid), 32'd1);
            check("gap_out_data", 32'(out_data), 32'h5A);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
